dm_arbiter: RTL and testbench
=============================

// Module: dm_arbiter
// PURPOSE
//  Shares the single-port data memory (dm_4k) between two bus masters: m0 = CPU MEM stage, m1 = device/DMA port.
//  Round-robin arbitration; latches the winning request, then generates word address, byte enables and write strobe.
//  Returns the raw 32-bit read word with a one-cycle ack pulse. Load sign/zero extension stays in the CPU.
// PARAMETERS
//  ADDR_W   12   byte-address width; memory word address is addr[ADDR_W-1:2]
// PORTS
//  clk        in   1   system clock, all state updates on posedge
//  rst        in   1   synchronous reset, active-high
//  m0_req     in   1   m0 request; held high with stable fields until m0_ack
//  m0_we      in   1   m0 write (1) / read (0)
//  m0_size    in   2   00 byte, 01 half, 10 word, 11 reserved (treated as error)
//  m0_addr    in   ADDR_W  m0 byte address
//  m0_wdata   in   32  m0 write data, right-justified (byte in [7:0], half in [15:0])
//  m0_ack     out  1   one-cycle completion pulse
//  m0_err     out  1   valid with m0_ack: misaligned/reserved access, no memory effect
//  m0_rdata   out  32  read word, valid with m0_ack on reads
//  m1_*       ...      identical set for master 1
//  dm_addr    out  ADDR_W-2  word address to memory
//  dm_din     out  32  write data to memory
//  dm_we      out  1   memory write strobe
//  dm_be      out  4   memory byte enables
//  dm_dout    in   32  memory combinational read data
// BEHAVIOUR
//  FSM: IDLE -> ISSUE -> RESP -> (ISSUE | IDLE). Reset: state=IDLE, last_grant=1 (m0 wins first tie), all outputs 0.
//  IDLE: if any req, pick the winner, latch its we/size/addr/wdata into the cmd regs, grant<=winner, go to ISSUE.
//  Arbitration: one req -> that master wins. Both req -> master != last_grant wins. last_grant updates on every latch.
//  ISSUE (1 cycle): dm_addr/dm_din/dm_be come from the cmd regs. dm_we=cmd_we & ~cmd_err.
//   Write commits at the ISSUE-ending edge. dm_dout is captured into the granted master's rdata reg at that edge.
//  RESP (1 cycle): granted master's ack=1, err=cmd_err; the other master's ack=0.
//   Also arbitrates for the next access, ignoring the just-acked master's req this cycle (it may hold req for back-to-back).
//   Winner found -> latch, go to ISSUE; none -> IDLE.
//  Latency: req seen in IDLE at cycle N -> ack in cycle N+2. Max throughput is one access per 2 cycles.
//  Byte enables: byte -> addr[1:0] 00:0001 01:0010 10:0100 11:1000.
//   half -> addr[1] 0:0011 1:1100. word -> 1111.
//  dm_din = cmd_wdata unchanged; the memory takes the lanes from the low bits.
//  cmd_err = (size==11) | (half & addr[0]) | (word & addr[1:0]!=0).
//   On error: no write, dm_be=0000, rdata holds its previous value, ack still pulses with err=1.
//  Outside ISSUE: dm_we=0 and dm_be=0000; dm_addr/dm_din hold the cmd regs. rdata regs hold until overwritten.
//  Requests held without change after ack are treated as new transactions.
//  rst mid-transfer: FSM aborts to IDLE and no ack is produced. A write already committed at an earlier edge is not undone.
//  ack/err/rdata registers cleared to 0.
// TESTING
//  T1 reset: rst=1 for 2 cycles -> all acks/err/dm_we=0, dm_be=0000, rdata=0.
//  T2 m0 word write 0xDEADBEEF @0x010, then read @0x010 -> dm_be=1111 in ISSUE; ack at N+2; rdata=0xDEADBEEF.
//  T3 m1 byte write 0xA5 @0x013 over 0x00000000, read back -> dm_be=1000; rdata=0xA5000000.
//   Half write 0x1234 @0x012 -> be=1100.
//  T4 m0 and m1 req in same cycle, both held for 4 transactions -> grants m0,m1,m0,m1.
//   One ack every 2 cycles; never both acks in one cycle.
//  T5 misaligned: m0 word @0x002, m1 half @0x001, size=11 -> err=1 with ack, dm_we never 1, memory unchanged.
//  T6 rst asserted in ISSUE of an m1 read -> no m1_ack; next cycle IDLE; a later m0 request wins with ack at N+2.

Source files
------------

// File: rtl/dm_arbiter.sv
// Round-robin arbiter sharing the single-port data memory between the CPU MEM stage (m0) and DMA (m1).
// Latches the winning command, drives one memory cycle, then returns a one-cycle ack with the raw read word.
module dm_arbiter #(
   parameter int ADDR_W = 12
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              m0_req,
   input  logic              m0_we,
   input  logic [1:0]        m0_size,
   input  logic [ADDR_W-1:0] m0_addr,
   input  logic [31:0]       m0_wdata,
   output logic              m0_ack,
   output logic              m0_err,
   output logic [31:0]       m0_rdata,
   input  logic              m1_req,
   input  logic              m1_we,
   input  logic [1:0]        m1_size,
   input  logic [ADDR_W-1:0] m1_addr,
   input  logic [31:0]       m1_wdata,
   output logic              m1_ack,
   output logic              m1_err,
   output logic [31:0]       m1_rdata,
   output logic [ADDR_W-3:0] dm_addr,
   output logic [31:0]       dm_din,
   output logic              dm_we,
   output logic [3:0]        dm_be,
   input  logic [31:0]       dm_dout
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_RESP  = 2'd2
   } state_t;

   state_t            r_state;
   state_t            w_next_state;
   logic              r_grant;
   logic              r_cmd_we;
   logic [1:0]        r_cmd_size;
   logic [ADDR_W-1:0] r_cmd_addr;
   logic [31:0]       r_cmd_wdata;
   logic              r_m0_ack;
   logic              r_m0_err;
   logic [31:0]       r_m0_rdata;
   logic              r_m1_ack;
   logic              r_m1_err;
   logic [31:0]       r_m1_rdata;

   logic              w_issue;
   logic              w_resp;
   logic              w_cand0;
   logic              w_cand1;
   logic              w_win_valid;
   logic              w_winner;
   logic              w_latch;
   logic              w_cmd_err;
   logic [3:0]        w_be;

   assign w_issue = (r_state == S_ISSUE);
   assign w_resp  = (r_state == S_RESP);

   // The master being acked sits out this arbitration, so a held req cannot starve the other side.
   assign w_cand0     = m0_req & ~(w_resp & ~r_grant);
   assign w_cand1     = m1_req & ~(w_resp & r_grant);
   assign w_win_valid = w_cand0 | w_cand1;
   assign w_winner    = (w_cand0 & w_cand1) ? ~r_grant : w_cand1;
   assign w_latch     = w_win_valid & ~w_issue;

   assign w_cmd_err = (r_cmd_size == 2'b11)
                    | ((r_cmd_size == 2'b01) & r_cmd_addr[0])
                    | ((r_cmd_size == 2'b10) & (r_cmd_addr[1:0] != 2'b00));

   always_comb begin
      // NOTE: default assignment first, so no path through the case leaves w_be unassigned and infers a latch.
      w_be = 4'b0000;
      case (r_cmd_size)
         2'b00:   w_be = 4'b0001 << r_cmd_addr[1:0];
         2'b01:   w_be = r_cmd_addr[1] ? 4'b1100 : 4'b0011;
         2'b10:   w_be = 4'b1111;
         default: w_be = 4'b0000;
      endcase
   end

   // NOTE: non-blocking assignments in clocked blocks, so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next_state;
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE:  w_next_state = w_win_valid ? S_ISSUE : S_IDLE;
         S_ISSUE: w_next_state = S_RESP;
         S_RESP:  w_next_state = w_win_valid ? S_ISSUE : S_IDLE;
         default: w_next_state = S_IDLE;
      endcase
   end

   always_comb begin
      dm_we = 1'b0;
      dm_be = 4'b0000;
      if (w_issue && !w_cmd_err) begin
         dm_we = r_cmd_we;
         dm_be = w_be;
      end
   end

   assign dm_addr  = r_cmd_addr[ADDR_W-1:2];
   assign dm_din   = r_cmd_wdata;
   assign m0_ack   = r_m0_ack;
   assign m0_err   = r_m0_err;
   assign m0_rdata = r_m0_rdata;
   assign m1_ack   = r_m1_ack;
   assign m1_err   = r_m1_err;
   assign m1_rdata = r_m1_rdata;

   // r_grant doubles as last_grant: both take the winner on every latch. Reset to 1 so m0 wins the first tie.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_grant     <= 1'b1;
         r_cmd_we    <= 1'b0;
         r_cmd_size  <= 2'b00;
         r_cmd_addr  <= '0;
         r_cmd_wdata <= '0;
         r_m0_ack    <= 1'b0;
         r_m0_err    <= 1'b0;
         r_m0_rdata  <= '0;
         r_m1_ack    <= 1'b0;
         r_m1_err    <= 1'b0;
         r_m1_rdata  <= '0;
      end else begin
         if (w_latch) begin
            r_grant     <= w_winner;
            r_cmd_we    <= w_winner ? m1_we    : m0_we;
            r_cmd_size  <= w_winner ? m1_size  : m0_size;
            r_cmd_addr  <= w_winner ? m1_addr  : m0_addr;
            r_cmd_wdata <= w_winner ? m1_wdata : m0_wdata;
         end
         r_m0_ack <= w_issue & ~r_grant;
         r_m0_err <= w_issue & ~r_grant & w_cmd_err;
         r_m1_ack <= w_issue & r_grant;
         r_m1_err <= w_issue & r_grant & w_cmd_err;
         if (w_issue && !w_cmd_err) begin
            if (r_grant) r_m1_rdata <= dm_dout;
            else         r_m0_rdata <= dm_dout;
         end
      end
   end

endmodule

// File: tb/tb_dm_arbiter.sv
// Bench for dm_arbiter: byte-addressed reference memory, per-master expectation queues and an ack monitor.
// Directed cases for reset, lanes, round-robin and errors, then randomized traffic from both masters.
module tb_dm_arbiter;

   logic        clk;
   logic        rst;
   logic        m0_req, m0_we, m1_req, m1_we;
   logic [1:0]  m0_size, m1_size;
   logic [11:0] m0_addr, m1_addr;
   logic [31:0] m0_wdata, m1_wdata;
   logic        m0_ack, m0_err, m1_ack, m1_err;
   logic [31:0] m0_rdata, m1_rdata;
   logic [9:0]  dm_addr;
   logic [31:0] dm_din, dm_dout;
   logic        dm_we;
   logic [3:0]  dm_be;

   dm_arbiter #(.ADDR_W(12)) dut (
      .clk(clk), .rst(rst),
      .m0_req(m0_req), .m0_we(m0_we), .m0_size(m0_size), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
      .m0_ack(m0_ack), .m0_err(m0_err), .m0_rdata(m0_rdata),
      .m1_req(m1_req), .m1_we(m1_we), .m1_size(m1_size), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
      .m1_ack(m1_ack), .m1_err(m1_err), .m1_rdata(m1_rdata),
      .dm_addr(dm_addr), .dm_din(dm_din), .dm_we(dm_we), .dm_be(dm_be), .dm_dout(dm_dout)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int cyc = 0;
   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // Memory behaves like dm_4k: the lowest enabled lane takes din[7:0], the next din[15:8], and so on.
   logic [31:0] mem [0:1023];
   initial for (int i = 0; i < 1024; i++) mem[i] = 32'd0;
   assign dm_dout = mem[dm_addr];

   function automatic logic [31:0] mem_merge(input logic [31:0] old, input logic [31:0] din, input logic [3:0] be);
      logic [31:0] res, sh;
      int lo;
      lo = 0;
      for (int i = 3; i >= 0; i--) if (be[i]) lo = i;
      sh  = din << (8 * lo);
      res = old;
      for (int i = 0; i < 4; i++) if (be[i]) res[8*i +: 8] = sh[8*i +: 8];
      return res;
   endfunction

   always @(posedge clk) if (dm_we) mem[dm_addr] <= mem_merge(mem[dm_addr], dm_din, dm_be);

   // ---------------- reference model ----------------
   typedef struct {
      logic        err;
      logic        chk_rdata;
      logic [31:0] rdata;
      logic [3:0]  be;
      logic        we;
   } exp_t;

   logic [7:0]  ref_bytes [0:4095];
   logic [31:0] last_rdata [2];
   exp_t        q0 [$];
   exp_t        q1 [$];
   int          ack_log [$];
   int          ack_cyc [$];
   int          n_checks = 0;
   int          n_fail = 0;

   initial begin
      for (int i = 0; i < 4096; i++) ref_bytes[i] = 8'd0;
      last_rdata[0] = 32'd0;
      last_rdata[1] = 32'd0;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic model_access(input int m, input logic we, input logic [1:0] size, input logic [11:0] addr,
                               input logic [31:0] wdata, output exp_t e);
      int a, nb, base;
      logic [31:0] old;
      a    = int'(addr);
      base = a - (a % 4);
      old  = {ref_bytes[base+3], ref_bytes[base+2], ref_bytes[base+1], ref_bytes[base]};
      e.err = (size == 2'd3);
      nb = 1;
      if (!e.err) begin
         nb    = 1 << size;
         e.err = (a % nb) != 0;
      end
      if (e.err) begin
         e.rdata     = last_rdata[m];
         e.chk_rdata = 1'b1;
         e.be        = 4'b0000;
         e.we        = 1'b0;
      end else begin
         e.rdata       = old;
         e.chk_rdata   = !we;
         e.be          = 4'(((1 << nb) - 1) << (a % 4));
         e.we          = we;
         last_rdata[m] = old;
         if (we) for (int i = 0; i < nb; i++) ref_bytes[a+i] = wdata[8*i +: 8];
      end
   endtask

   // ---------------- monitor ----------------
   task automatic check_resp(input int m, input logic [3:0] prev_be, input logic prev_we);
      exp_t e;
      logic [31:0] rd;
      logic er;
      ack_log.push_back(m);
      ack_cyc.push_back(cyc);
      if ((m == 0 && q0.size() == 0) || (m == 1 && q1.size() == 0)) begin
         check($sformatf("m%0d_unexpected_ack", m), 32'd1, 32'd0);
         return;
      end
      if (m == 0) begin e = q0.pop_front(); rd = m0_rdata; er = m0_err; end
      else        begin e = q1.pop_front(); rd = m1_rdata; er = m1_err; end
      check($sformatf("m%0d_err", m), {31'd0, er}, {31'd0, e.err});
      if (e.chk_rdata) check($sformatf("m%0d_rdata", m), rd, e.rdata);
      check($sformatf("m%0d_issue_be", m), {28'd0, prev_be}, {28'd0, e.be});
      check($sformatf("m%0d_issue_we", m), {31'd0, prev_we}, {31'd0, e.we});
   endtask

   initial begin
      logic [3:0] prev_be;
      logic       prev_we;
      prev_be = 4'd0;
      prev_we = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst) begin
            if (m0_ack || m1_ack) check("dual_ack", {31'd0, m0_ack & m1_ack}, 32'd0);
            if (m0_ack) check_resp(0, prev_be, prev_we);
            if (m1_ack) check_resp(1, prev_be, prev_we);
         end
         prev_be = dm_be;
         prev_we = dm_we;
      end
   end

   // ---------------- drivers ----------------
   task automatic drive(input int m, input logic we, input logic [1:0] size, input logic [11:0] addr,
                        input logic [31:0] wdata, input int exp_lat);
      exp_t e;
      int   lat;
      logic got;
      model_access(m, we, size, addr, wdata, e);
      if (m == 0) begin
         q0.push_back(e);
         m0_we = we; m0_size = size; m0_addr = addr; m0_wdata = wdata; m0_req = 1'b1;
      end else begin
         q1.push_back(e);
         m1_we = we; m1_size = size; m1_addr = addr; m1_wdata = wdata; m1_req = 1'b1;
      end
      lat = 0;
      got = 1'b0;
      while (!got && lat < 20) begin
         @(negedge clk);
         lat++;
         got = (m == 0) ? m0_ack : m1_ack;
      end
      if (m == 0) m0_req = 1'b0;
      else        m1_req = 1'b0;
      if (!got) begin
         check($sformatf("m%0d_timeout", m), 32'd0, 32'd1);
         if (m == 0) q0.delete(q0.size() - 1);
         else        q1.delete(q1.size() - 1);
      end else if (exp_lat > 0) begin
         check($sformatf("m%0d_latency", m), 32'(lat), 32'(exp_lat));
      end
   endtask

   task automatic do_reset(input int n);
      rst = 1'b1;
      repeat (n) @(negedge clk);
      rst = 1'b0;
      last_rdata[0] = 32'd0;
      last_rdata[1] = 32'd0;
   endtask

   task automatic rand_traffic(input int m, input int n, input int base);
      for (int i = 0; i < n; i++) begin
         repeat ($urandom_range(0, 2)) @(negedge clk);
         drive(m, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
               12'(base + $urandom_range(0, 1023)), $urandom, 0);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
      $fatal(1, "watchdog");
   end

   // ---------------- test sequence ----------------
   initial begin
      int start;
      rst = 1'b1;
      m0_req = 1'b0; m0_we = 1'b0; m0_size = 2'd0; m0_addr = '0; m0_wdata = '0;
      m1_req = 1'b0; m1_we = 1'b0; m1_size = 2'd0; m1_addr = '0; m1_wdata = '0;

      // T1: reset state
      repeat (2) @(negedge clk);
      check("rst_m0_ack",   {31'd0, m0_ack}, 32'd0);
      check("rst_m0_err",   {31'd0, m0_err}, 32'd0);
      check("rst_m0_rdata", m0_rdata, 32'd0);
      check("rst_m1_ack",   {31'd0, m1_ack}, 32'd0);
      check("rst_m1_err",   {31'd0, m1_err}, 32'd0);
      check("rst_m1_rdata", m1_rdata, 32'd0);
      check("rst_dm_we",    {31'd0, dm_we}, 32'd0);
      check("rst_dm_be",    {28'd0, dm_be}, 32'd0);
      rst = 1'b0;
      @(negedge clk);

      // T3: byte and half lanes from m1
      drive(1, 1'b1, 2'd0, 12'h013, 32'h000000A5, 2);
      @(negedge clk);
      drive(1, 1'b0, 2'd2, 12'h010, 32'd0, 2);
      check("t3_byte_rdata", m1_rdata, 32'hA5000000);
      @(negedge clk);
      drive(1, 1'b1, 2'd1, 12'h012, 32'h00001234, 2);
      @(negedge clk);
      drive(1, 1'b0, 2'd2, 12'h010, 32'd0, 2);
      check("t3_half_rdata", m1_rdata, 32'h12340000);
      @(negedge clk);

      // T2: m0 word write then read
      drive(0, 1'b1, 2'd2, 12'h010, 32'hDEADBEEF, 2);
      @(negedge clk);
      drive(0, 1'b0, 2'd2, 12'h010, 32'd0, 2);
      check("t2_word_rdata", m0_rdata, 32'hDEADBEEF);
      @(negedge clk);

      // T5: misaligned and reserved accesses, then confirm memory untouched
      drive(0, 1'b1, 2'd2, 12'h002, 32'h11111111, 2);
      drive(1, 1'b1, 2'd1, 12'h001, 32'h00002222, 0);
      drive(1, 1'b1, 2'd3, 12'h020, 32'h33333333, 0);
      drive(0, 1'b0, 2'd3, 12'h010, 32'd0, 0);
      @(negedge clk);
      drive(0, 1'b0, 2'd2, 12'h000, 32'd0, 0);
      check("t5_mem0_unchanged", m0_rdata, 32'd0);
      drive(1, 1'b0, 2'd2, 12'h020, 32'd0, 0);
      check("t5_mem20_unchanged", m1_rdata, 32'd0);
      @(negedge clk);

      // T4: simultaneous held requests alternate m0,m1,... one ack every 2 cycles
      do_reset(2);
      start = ack_log.size();
      fork
         for (int i = 0; i < 4; i++) drive(0, 1'(i % 2), 2'd2, 12'(12'h100 + 4 * i), 32'(32'hA0 + i), 0);
         for (int i = 0; i < 4; i++) drive(1, 1'(i % 2), 2'd2, 12'(12'h200 + 4 * i), 32'(32'hB0 + i), 0);
      join
      check("t4_ack_count", 32'(ack_log.size() - start), 32'd8);
      for (int i = 0; i < 8 && start + i < ack_log.size(); i++) begin
         check($sformatf("t4_grant_%0d", i), 32'(ack_log[start+i]), 32'(i % 2));
         if (i > 0) check($sformatf("t4_gap_%0d", i), 32'(ack_cyc[start+i] - ack_cyc[start+i-1]), 32'd2);
      end
      @(negedge clk);

      // Randomized traffic, disjoint address regions per master
      fork
         rand_traffic(0, 30, 12'h800);
         rand_traffic(1, 30, 12'hC00);
      join
      repeat (2) @(negedge clk);

      // T6: reset during ISSUE of an m1 read aborts it
      m1_we = 1'b0; m1_size = 2'd2; m1_addr = 12'h010; m1_req = 1'b1;
      @(negedge clk);
      rst = 1'b1;
      m1_req = 1'b0;
      @(negedge clk);
      check("t6_no_ack_rst", {31'd0, m1_ack}, 32'd0);
      check("t6_m0_rdata_clr", m0_rdata, 32'd0);
      check("t6_m1_rdata_clr", m1_rdata, 32'd0);
      rst = 1'b0;
      last_rdata[0] = 32'd0;
      last_rdata[1] = 32'd0;
      @(negedge clk);
      check("t6_no_ack_after", {31'd0, m1_ack}, 32'd0);
      drive(0, 1'b0, 2'd2, 12'h010, 32'd0, 2);
      check("t6_m0_rdata", m0_rdata, 32'hDEADBEEF);

      repeat (3) @(negedge clk);
      check("q0_drained", 32'(q0.size()), 32'd0);
      check("q1_drained", 32'(q1.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
